// File: rtl/dmem_access_unit_pkg.sv
// Shared types for the MEM-stage data-memory access unit: funct3 encodings,
// FSM state and the registered request word.
package dmem_access_unit_pkg;
  localparam int WORD_W    = 32;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } dmem_state_t;

  typedef struct packed {
    logic [WORD_W-1:0]    addr;
    logic [NUM_LANES-1:0] wmask;
    logic [WORD_W-1:0]    wdata;
    logic [2:0]           funct3;
    logic                 is_read;
  } mem_req_t;

  // funct3[1:0] encodes access size for both loads and stores
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: store mask/data alignment and load extract/extend.
// Purely combinational.
module dmem_lane_fmt
  import dmem_access_unit_pkg::*;
(
  input  logic [1:0]           st_size,
  input  logic [1:0]           st_off,
  input  logic [WORD_W-1:0]    st_data,
  output logic [NUM_LANES-1:0] st_mask,
  output logic [WORD_W-1:0]    st_wdata,
  input  logic [2:0]           ld_funct3,
  input  logic [1:0]           ld_off,
  input  logic [WORD_W-1:0]    ld_raw,
  output logic [WORD_W-1:0]    ld_data
);
  logic [NUM_LANES-1:0][LANE_W-1:0] ld_lanes;
  logic [LANE_W-1:0]                ld_b;
  logic [2*LANE_W-1:0]              ld_h;

  assign ld_lanes = ld_raw;

  always_comb begin
    case (st_size)
      2'b00:   st_mask = 4'b0001 << st_off;
      2'b01:   st_mask = 4'b0011 << st_off;
      default: st_mask = 4'b1111;
    endcase
    st_wdata = st_data << {st_off, 3'b000};
  end

  always_comb begin
    ld_b = ld_lanes[ld_off];
    ld_h = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (load_funct3_t'(ld_funct3))
      F3_LB:   ld_data = {{24{ld_b[7]}}, ld_b};
      F3_LBU:  ld_data = {24'd0, ld_b};
      F3_LH:   ld_data = {{16{ld_h[15]}}, ld_h};
      F3_LHU:  ld_data = {16'd0, ld_h};
      default: ld_data = ld_raw;
    endcase
  end
endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: runs the request/response handshake,
// formats load/store data and stalls the pipeline until MEM/WB takes the result.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DMEM_TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_dmem_read,
  input  logic            in_dmem_write,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            flush,
  input  logic            wb_ready,
  output logic [XLEN-1:0] dmem_address,
  output logic            dmem_read,
  output logic            dmem_write,
  output logic [3:0]      dmem_wmask,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_resp,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_misaligned,
  output logic            out_timeout
);
  dmem_state_t          state;
  mem_req_t             req;
  mem_req_t             new_req;
  logic                 accept;
  logic                 misal;
  logic [NUM_LANES-1:0] st_mask;
  logic [WORD_W-1:0]    st_wdata;
  logic [WORD_W-1:0]    ld_data;

  dmem_lane_fmt u_fmt (
    .st_size   (in_funct3[1:0]),
    .st_off    (in_addr[1:0]),
    .st_data   (in_wdata),
    .st_mask   (st_mask),
    .st_wdata  (st_wdata),
    .ld_funct3 (req.funct3),
    .ld_off    (req.addr[1:0]),
    .ld_raw    (dmem_rdata),
    .ld_data   (ld_data)
  );

  assign accept = (state == IDLE) & in_valid & (in_dmem_read | in_dmem_write) & ~flush;
  assign misal  = is_misaligned(in_funct3[1:0], in_addr[1:0]);

  // a read+write combination is treated as a read
  always_comb begin
    new_req         = '0;
    new_req.addr    = in_addr;
    new_req.funct3  = in_funct3;
    new_req.is_read = in_dmem_read;
    if (!in_dmem_read) begin
      new_req.wmask = st_mask;
      new_req.wdata = st_wdata;
    end
  end

  assign dmem_address = {req.addr[31:2], 2'b00};
  assign dmem_wmask   = req.wmask;
  assign dmem_wdata   = req.wdata;

  assign stall = ~rst & (accept | (state == BUSY) | (state == DRAIN) |
                         ((state == HOLD) & ~wb_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      req            <= '0;
      dmem_read      <= 1'b0;
      dmem_write     <= 1'b0;
      out_valid      <= 1'b0;
      out_rdata      <= '0;
      out_misaligned <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (misal) begin
            state          <= HOLD;
            out_valid      <= 1'b1;
            out_misaligned <= 1'b1;
            out_rdata      <= '0;
          end else begin
            state      <= BUSY;
            req        <= new_req;
            dmem_read  <= in_dmem_read;
            dmem_write <= ~in_dmem_read;
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            req        <= '0;
            if (flush) begin
              state <= IDLE;
            end else begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_rdata <= req.is_read ? ld_data : '0;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        // request stays on the bus until memory answers; the answer is dropped
        DRAIN: if (dmem_resp) begin
          state      <= IDLE;
          dmem_read  <= 1'b0;
          dmem_write <= 1'b0;
          req        <= '0;
        end
        HOLD: if (flush | wb_ready) begin
          state          <= IDLE;
          out_valid      <= 1'b0;
          out_misaligned <= 1'b0;
          out_rdata      <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    if (DMEM_TIMEOUT > 0) begin : g_to
      localparam int CW = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT + 1) : 1;
      logic [CW-1:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt         <= '0;
          out_timeout <= 1'b0;
        end else if ((state == BUSY) || (state == DRAIN)) begin
          if (cnt != CW'(DMEM_TIMEOUT)) cnt <= cnt + 1'b1;
          if (cnt == CW'(DMEM_TIMEOUT - 1)) out_timeout <= 1'b1;
        end else begin
          cnt <= '0;
        end
      end
    end else begin : g_no_to
      assign out_timeout = 1'b0;
    end
  endgenerate
endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit; results are checked against a queue of
// expected (rdata, misaligned) pairs filled as each op is issued.
module tb_dmem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_dmem_read, in_dmem_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        flush, wb_ready;
  logic [31:0] dmem_address;
  logic        dmem_read, dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_resp;
  logic        stall, out_valid, out_misaligned, out_timeout;
  logic [31:0] out_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dmem_access_unit #(.XLEN(32), .DMEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_dmem_read(in_dmem_read), .in_dmem_write(in_dmem_write),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .flush(flush), .wb_ready(wb_ready),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .stall(stall), .out_valid(out_valid),
    .out_rdata(out_rdata), .out_misaligned(out_misaligned), .out_timeout(out_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    in_valid = 1'b1; in_dmem_read = rd; in_dmem_write = wr;
    in_funct3 = f3; in_addr = a; in_wdata = wd;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_dmem_read = 1'b0; in_dmem_write = 1'b0;
  endtask

  // result handshake monitor
  always @(negedge clk) begin
    if (!rst && out_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_out_rdata", out_rdata, e.rdata);
        chk("sb_out_misaligned", {31'd0, out_misaligned}, {31'd0, e.mis});
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; wb_ready = 1'b1; dmem_resp = 1'b0; dmem_rdata = '0;
    in_funct3 = '0; in_addr = '0; in_wdata = '0;
    idle_in();
    #12;
    chk("rst_dmem_read", {31'd0, dmem_read}, 32'd0);
    chk("rst_dmem_address", dmem_address, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_timeout", {31'd0, out_timeout}, 32'd0);
    rst = 1'b0;
    step();

    // lb from byte 3, sign-extended
    issue(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0);
    #1;
    chk("lb_accept_stall", {31'd0, stall}, 32'd1);
    chk("lb_read_not_yet", {31'd0, dmem_read}, 32'd0);
    exp_q.push_back('{32'hFFFF_FF80, 1'b0});
    step();
    idle_in();
    chk("lb_address", dmem_address, 32'h0000_1000);
    chk("lb_read", {31'd0, dmem_read}, 32'd1);
    chk("lb_wmask", {28'd0, dmem_wmask}, 32'd0);
    dmem_rdata = 32'h80FF_0000; dmem_resp = 1'b1;
    step();
    dmem_resp = 1'b0;
    chk("lb_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("lb_read_dropped", {31'd0, dmem_read}, 32'd0);
    chk("lb_stall_drop", {31'd0, stall}, 32'd0);
    step();
    chk("lb_idle_valid", {31'd0, out_valid}, 32'd0);

    // sh to upper half
    issue(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF);
    exp_q.push_back('{32'd0, 1'b0});
    step();
    idle_in();
    chk("sh_address", dmem_address, 32'h0000_2000);
    chk("sh_wmask", {28'd0, dmem_wmask}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEF_0000);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("sh_write_held", {31'd0, dmem_write}, 32'd1);
      chk("sh_stall_busy", {31'd0, stall}, 32'd1);
    end
    dmem_resp = 1'b1;
    step();
    dmem_resp = 1'b0;
    chk("sh_write_dropped", {31'd0, dmem_write}, 32'd0);
    chk("sh_out_valid", {31'd0, out_valid}, 32'd1);
    step();

    // misaligned lw
    issue(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'd0);
    #1;
    chk("mis_accept_stall", {31'd0, stall}, 32'd1);
    exp_q.push_back('{32'd0, 1'b1});
    step();
    idle_in();
    chk("mis_no_read", {31'd0, dmem_read}, 32'd0);
    chk("mis_out_valid", {31'd0, out_valid}, 32'd1);
    chk("mis_flag", {31'd0, out_misaligned}, 32'd1);
    step();
    chk("mis_no_read_after", {31'd0, dmem_read}, 32'd0);
    chk("mis_idle_valid", {31'd0, out_valid}, 32'd0);

    // flush in 2nd BUSY cycle, resp three cycles later
    issue(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'd0);
    step();
    idle_in();
    chk("fl_read_b1", {31'd0, dmem_read}, 32'd1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("fl_read_held", {31'd0, dmem_read}, 32'd1);
      chk("fl_stall_drain", {31'd0, stall}, 32'd1);
      chk("fl_no_valid", {31'd0, out_valid}, 32'd0);
      step();
    end
    dmem_rdata = 32'h1234_5678; dmem_resp = 1'b1;
    step();
    dmem_resp = 1'b0;
    chk("fl_read_released", {31'd0, dmem_read}, 32'd0);
    chk("fl_no_valid_after", {31'd0, out_valid}, 32'd0);
    chk("fl_stall_idle", {31'd0, stall}, 32'd0);

    // non-memory op and flush-in-IDLE both leave the unit idle
    issue(1'b0, 1'b0, 3'b000, 32'h0000_5000, 32'd0);
    #1;
    chk("nonmem_stall", {31'd0, stall}, 32'd0);
    step();
    chk("nonmem_read", {31'd0, dmem_read}, 32'd0);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'd0);
    flush = 1'b1;
    #1;
    chk("idleflush_stall", {31'd0, stall}, 32'd0);
    step();
    flush = 1'b0;
    idle_in();
    chk("idleflush_read", {31'd0, dmem_read}, 32'd0);

    // lhu with MEM/WB back-pressure
    wb_ready = 1'b0;
    issue(1'b1, 1'b0, 3'b101, 32'h0000_5000, 32'd0);
    exp_q.push_back('{32'h0000_8001, 1'b0});
    step();
    idle_in();
    dmem_rdata = 32'hFFFF_8001; dmem_resp = 1'b1;
    step();
    dmem_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lhu_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("lhu_rdata_hold", out_rdata, 32'h0000_8001);
      chk("lhu_stall_hold", {31'd0, stall}, 32'd1);
      if (i < 3) step();
    end
    wb_ready = 1'b1;
    #1;
    chk("lhu_stall_release", {31'd0, stall}, 32'd0);
    step();
    chk("lhu_idle_valid", {31'd0, out_valid}, 32'd0);

    // no response: timeout after 8 BUSY cycles, then async reset
    issue(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'd0);
    step();
    idle_in();
    for (int i = 0; i < 7; i++) step();
    chk("to_not_yet", {31'd0, out_timeout}, 32'd0);
    step();
    chk("to_set", {31'd0, out_timeout}, 32'd1);
    chk("to_read_still", {31'd0, dmem_read}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_timeout", {31'd0, out_timeout}, 32'd0);
    chk("arst_read", {31'd0, dmem_read}, 32'd0);
    chk("arst_address", dmem_address, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_read", {31'd0, dmem_read}, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
